// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble), one shift per clock.
// Optional invalid-digit check enabled by macro BCD_TO_BIN_CHECK_EN.
module bcd_to_bin #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [BIN_W-1:0]      bin_q;
  logic [CW-1:0]         cnt_q;
  logic [4*DIGITS-1:0]   sh_bcd;
  logic [4*DIGITS-1:0]   corr_bcd;
  logic [BIN_W-1:0]      sh_bin;
  logic                  load;
  logic                  bad_digit;

  // One reverse-dabble step: shift {bcd,bin} right, then fix digits that reached 8+.
  always_comb begin
    sh_bin   = {bcd_q[0], bin_q[BIN_W-1:1]};
    sh_bcd   = {1'b0, bcd_q[4*DIGITS-1:1]};
    corr_bcd = sh_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd8)
        corr_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
    end
  end

`ifdef BCD_TO_BIN_CHECK_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = bad_digit ? HOLD : CONV;
        end
      end
      CONV: begin
        if (cnt_q == '0) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      bcd_q <= bcd_in;
      bin_q <= '0;
      cnt_q <= CW'(BIN_W - 1);
    end else if (state_q == CONV) begin
      bcd_q <= corr_bcd;
      bin_q <= sh_bin;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef BCD_TO_BIN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)       err_q <= 1'b0;
    else if (load) err_q <= bad_digit;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: expected values queued at input acceptance, compared at output.
module tb_bcd_to_bin;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic                clk = 1'b0;
  logic                rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [4*DIGITS-1:0] bcd_in;
  logic [BIN_W-1:0]    bin_out;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
    .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bcd_in = '0;
    step(); step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (bin_out !== '0) begin errors++; $display("FAIL reset_bin_out got=%0d exp=0", bin_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_999();
    logic [BIN_W-1:0] e;
    bit rdy_bad = 1'b0, early = 1'b0;
    bcd_in = 12'h999; in_valid = 1'b1;
    exp_q.push_back(999);
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      if (c < 11 && out_valid !== 1'b0) early = 1'b1;
      if (c < 11) step();
    end
    checks++; if (rdy_bad) begin errors++; $display("FAIL c999_in_ready_busy got=high exp=low in cycles 1-11"); end
    checks++; if (early) begin errors++; $display("FAIL c999_early_out got=out_valid before cycle 11 exp=none"); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL c999_latency got=%b exp=1 at cycle 11", out_valid); end
    e = BIN_W'(exp_q.pop_front());
    checks++; if (bin_out !== e) begin errors++; $display("FAIL c999_value got=%0d exp=%0d", bin_out, e); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL c999_err got=%b exp=0", err); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL c999_back_idle got=rdy%b/vld%b exp=rdy1/vld0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] items [2] = '{12'h000, 12'h010};
    int vals [2] = '{0, 10};
    int acc_cyc [2] = '{0, 0};
    int n_acc = 0, n_out = 0;
    bit acc;
    logic [BIN_W-1:0] e;
    out_ready = 1'b1; bcd_in = items[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && n_out < 2; cyc++) begin
      acc = in_valid && in_ready;
      if (acc) begin acc_cyc[n_acc] = cyc; exp_q.push_back(vals[n_acc]); n_acc++; end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected got=%0d exp=no output", bin_out); end
        else begin
          e = BIN_W'(exp_q.pop_front());
          if (bin_out !== e) begin errors++; $display("FAIL b2b_value got=%0d exp=%0d", bin_out, e); end
        end
        n_out++;
      end
      step();
      if (acc) begin
        if (n_acc < 2) bcd_in = items[n_acc];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (n_out != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", n_out); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != 12) begin
      errors++; $display("FAIL b2b_interval got=%0d exp=12", acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [BIN_W-1:0] e;
    bit ok, bad = 1'b0;
    bcd_in = 12'h256; in_valid = 1'b1;
    exp_q.push_back(256);
    step();
    in_valid = 1'b0;
    wait_out(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=no out_valid exp=out_valid"); end
    e = BIN_W'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || bin_out !== e || in_ready !== 1'b0 || err !== 1'b0) bad = 1'b1;
      step();
    end
    checks++; if (bad) begin errors++; $display("FAIL bp_hold got=unstable exp=bin %0d held, in_ready 0", e); end
    out_ready = 1'b1;
    checks++; if (bin_out !== e || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_value got=%0d/vld%b exp=%0d/vld1", bin_out, out_valid, e);
    end
    step();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got=rdy%b/vld%b exp=rdy1/vld0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [BIN_W-1:0] e;
    bit ok, seen = 1'b0;
    bcd_in = 12'h483; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || bin_out !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_state got=vld%b/bin%0d/rdy%b exp=vld0/bin0/rdy1", out_valid, bin_out, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      step();
    end
    out_ready = 1'b0;
    checks++; if (seen) begin errors++; $display("FAIL rstmid_ghost got=output after reset exp=none"); end
    bcd_in = 12'h123; in_valid = 1'b1;
    exp_q.push_back(123);
    step();
    in_valid = 1'b0;
    wait_out(30, ok);
    e = BIN_W'(exp_q.pop_front());
    checks++; if (!ok || bin_out !== e) begin
      errors++; $display("FAIL rstmid_next got=vld%b/%0d exp=vld1/%0d", ok, bin_out, e);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_sweep();
    int rcv = 0;
    logic [BIN_W-1:0] e;
    fork
      begin
        bit accepted;
        for (int v = 0; v < 1000; v++) begin
          repeat ($urandom_range(0, 2)) step();
          bcd_in = to_bcd(v); in_valid = 1'b1;
          accepted = 1'b0;
          for (int t = 0; t < 100; t++) begin
            if (in_ready === 1'b1) begin accepted = 1'b1; break; end
            step();
          end
          if (!accepted) begin
            checks++; errors++; $display("FAIL sweep_accept got=no in_ready exp=accept of %0d", v);
            in_valid = 1'b0;
            break;
          end
          exp_q.push_back(v);
          step();
          in_valid = 1'b0;
        end
      end
      begin
        for (int t = 0; t < 60000 && rcv < 1000; t++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL sweep_extra got=%0d exp=no output", bin_out); end
            else begin
              e = BIN_W'(exp_q.pop_front());
              if (bin_out !== e || err !== 1'b0) begin
                errors++; $display("FAIL sweep_value got=%0d/err%b exp=%0d/err0", bin_out, err, e);
              end
            end
            rcv++;
          end
          step();
        end
        out_ready = 1'b0;
      end
    join
    checks++; if (rcv != 1000) begin errors++; $display("FAIL sweep_count got=%0d exp=1000", rcv); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sweep_leftover got=%0d exp=0", exp_q.size()); end
  endtask

`ifdef BCD_TO_BIN_CHECK_EN
  task automatic test_check_en();
    logic [BIN_W-1:0] e;
    bit ok;
    bcd_in = 12'h0A5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || err !== 1'b1 || bin_out !== '0) begin
      errors++; $display("FAIL chk_bad got=vld%b/err%b/bin%0d exp=vld1/err1/bin0", out_valid, err, bin_out);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    bcd_in = 12'h095; in_valid = 1'b1;
    exp_q.push_back(95);
    step();
    in_valid = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_err_clear got=%b exp=0", err); end
    wait_out(30, ok);
    e = BIN_W'(exp_q.pop_front());
    checks++; if (!ok || bin_out !== e || err !== 1'b0) begin
      errors++; $display("FAIL chk_good got=vld%b/%0d/err%b exp=vld1/%0d/err0", ok, bin_out, err, e);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_999();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef BCD_TO_BIN_CHECK_EN
    test_check_en();
`endif
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
